// File: rtl/nios2_debug_slave_sysclk_bridge.sv
// System-clock half of the Nios II JTAG debug slave: strobe synchronisers, command FIFO, action decode.
// Optional feature macro: DBG_SYSCLK_BRIDGE_DROP_CNT_EN (saturating dropped-command counter).
module nios2_debug_slave_sysclk_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 2,
    localparam int CH         = 2 ** IR_W,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic              cmd_ready,
    input  logic              ovf_clr,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] jdo,
    output logic [CH-1:0]     take_action,
    output logic [CH-1:0]     take_no_action,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = IR_W + DATA_W;

    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q, warm_q;
    logic                   uir_prev_q, udr_prev_q, uir_p_q, udr_p_q;
    logic [IR_W-1:0]        ir_reg_q;

    // prev is held at 1 until the chain has refilled after reset, so a strobe
    // held high across reset release is never seen as a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            warm_q     <= '0;
            uir_prev_q <= 1'b1;
            udr_prev_q <= 1'b1;
            uir_p_q    <= 1'b0;
            udr_p_q    <= 1'b0;
            ir_reg_q   <= '0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            warm_q     <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            uir_prev_q <= warm_q[SYNC_STAGES-1] ? uir_sync_q[SYNC_STAGES-1] : 1'b1;
            udr_prev_q <= warm_q[SYNC_STAGES-1] ? udr_sync_q[SYNC_STAGES-1] : 1'b1;
            uir_p_q    <= uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
            udr_p_q    <= udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
            if (uir_p_q) ir_reg_q <= ir_in;
        end
    end

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, pop, push, drop;

    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign cmd_valid = (level_q != '0);
    assign {cmd_ir, cmd_data} = mem_q[rd_ptr_q];
    assign pop       = cmd_valid & cmd_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push      = udr_p_q & (~full | pop);
    assign drop      = udr_p_q & full & ~pop;
    assign fifo_level = level_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ir_reg_q, sr};
    end

    logic              pend_q, pend_act_q;
    logic [IR_W-1:0]   pend_ir_q;
    logic [DATA_W-1:0] jdo_q;
    logic [CH-1:0]     ta_q, tna_q, pend_oh;
    logic              ovf_q;

    assign pend_oh = CH'(1) << pend_ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            pend_q     <= 1'b0;
            pend_act_q <= 1'b0;
            pend_ir_q  <= '0;
            jdo_q      <= '0;
            ta_q       <= '0;
            tna_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                jdo_q    <= cmd_data;
            end
            pend_q     <= pop;
            pend_act_q <= cmd_data[ACT_BIT];
            pend_ir_q  <= cmd_ir;
            ta_q       <= (pend_q &  pend_act_q) ? pend_oh : '0;
            tna_q      <= (pend_q & ~pend_act_q) ? pend_oh : '0;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign overflow       = ovf_q;

`ifdef DBG_SYSCLK_BRIDGE_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)        drop_cnt_q <= '0;
        else if (drop)    drop_cnt_q <= ovf_clr ? 8'd1 : (drop_cnt_q == 8'hFF ? 8'hFF : drop_cnt_q + 8'd1);
        else if (ovf_clr) drop_cnt_q <= '0;
    end
    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nios2_debug_slave_sysclk_bridge.sv
// Directed bench for nios2_debug_slave_sysclk_bridge with default parameters.
module tb_nios2_debug_slave_sysclk_bridge;
    localparam int DATA_W = 38;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] sr = '0;
    logic [1:0]        ir_in = '0;
    logic              vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b0, ovf_clr = 1'b0;
    logic              cmd_valid, overflow;
    logic [1:0]        cmd_ir;
    logic [DATA_W-1:0] cmd_data, jdo;
    logic [3:0]        take_action, take_no_action;
    logic [2:0]        fifo_level;
    logic [7:0]        drop_cnt;

    int nvec = 0;
    int nerr = 0;

`ifdef DBG_SYSCLK_BRIDGE_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    nios2_debug_slave_sysclk_bridge dut (
        .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .cmd_ready(cmd_ready), .ovf_clr(ovf_clr), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir),
        .cmd_data(cmd_data), .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic negs(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_uir(input logic [1:0] ir);
        ir_in = ir; vs_uir = 1'b1; negs(3);
        vs_uir = 1'b0; negs(4);
    endtask

    task automatic do_udr(input logic [DATA_W-1:0] d);
        sr = d; vs_udr = 1'b1; negs(3);
        vs_udr = 1'b0; negs(4);
    endtask

    logic [DATA_W-1:0] dv [6];
    logic [DATA_W-1:0] d1, d2;

    initial begin
        d1 = {1'b1, 5'd0, 32'hDEADBEEF};
        d2 = {1'b0, 5'd0, 32'h12345678};
        for (int i = 0; i < 6; i++)
            dv[i] = {(i % 2 == 0), 5'd0, 32'hA0000000 + 32'(i * 17)};

        // reset state
        negs(3);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_pulses", 64'({take_action, take_no_action}), 64'd0);
        chk("rst_ovf", 64'({overflow, drop_cnt}), 64'd0);
        reset = 1'b0; negs(4);

        // action path: ir=01, sr[37]=1
        cmd_ready = 1'b1;
        do_uir(2'b01);
        sr = d1; vs_udr = 1'b1;
        negs(3);
        chk("t1_valid_e2", 64'(cmd_valid), 64'd0);
        negs(1);
        chk("t1_valid_e3", 64'(cmd_valid), 64'd1);
        chk("t1_level_e3", 64'(fifo_level), 64'd1);
        chk("t1_cmd_ir", 64'(cmd_ir), 64'd1);
        negs(1);
        chk("t1_valid_e4", 64'(cmd_valid), 64'd0);
        chk("t1_jdo", 64'(jdo[31:0]), 64'hDEADBEEF);
        chk("t1_ta_e4", 64'(take_action), 64'd0);
        negs(1);
        chk("t1_ta_e5", 64'(take_action), 64'b0010);
        chk("t1_tna_e5", 64'(take_no_action), 64'd0);
        vs_udr = 1'b0;
        negs(1);
        chk("t1_ta_e6", 64'(take_action), 64'd0);
        negs(4);

        // no-action path: ir=11, sr[37]=0
        do_uir(2'b11);
        sr = d2; vs_udr = 1'b1;
        negs(6);
        chk("t2_tna_e5", 64'(take_no_action), 64'b1000);
        chk("t2_ta_e5", 64'(take_action), 64'd0);
        vs_udr = 1'b0;
        negs(1);
        chk("t2_tna_e6", 64'(take_no_action), 64'd0);
        negs(4);

        // overflow: six strobes into a 4-deep queue
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) do_udr(dv[i]);
        chk("t3_level", 64'(fifo_level), 64'd4);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_cnt), CNT_EN ? 64'd2 : 64'd0);
        chk("t3_head", 64'(cmd_data), 64'(dv[0]));
        chk("t3_head_ir", 64'(cmd_ir), 64'd3);
        cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            negs(1);
            if (k < 4) chk($sformatf("t3_jdo%0d", k), 64'(jdo), 64'(dv[k]));
            if (k == 0) chk("t3_pulse0", 64'({take_action, take_no_action}), 64'd0);
            else chk($sformatf("t3_pulse%0d", k), 64'({take_action, take_no_action}),
                     dv[k-1][37] ? 64'h80 : 64'h08);
        end
        chk("t3_empty", 64'(fifo_level), 64'd0);
        negs(1);
        chk("t3_pulse_end", 64'({take_action, take_no_action}), 64'd0);

        // clear, then drop coinciding with clear
        cmd_ready = 1'b0;
        ovf_clr = 1'b1; negs(1); ovf_clr = 1'b0;
        chk("clr_ovf", 64'({overflow, drop_cnt}), 64'd0);
        for (int i = 0; i < 4; i++) do_udr(dv[i]);
        chk("full_level", 64'(fifo_level), 64'd4);
        sr = dv[4]; vs_udr = 1'b1; negs(3);
        ovf_clr = 1'b1; negs(1); ovf_clr = 1'b0;
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
        chk("clrdrop_cnt", 64'(drop_cnt), CNT_EN ? 64'd1 : 64'd0);
        vs_udr = 1'b0; negs(3);
        ovf_clr = 1'b1; negs(1); ovf_clr = 1'b0;
        chk("clr2_ovf", 64'({overflow, drop_cnt}), 64'd0);

        // full with push and pop in the same cycle
        sr = dv[5]; vs_udr = 1'b1; negs(3);
        cmd_ready = 1'b1; negs(1); cmd_ready = 1'b0;
        chk("pp_level", 64'(fifo_level), 64'd4);
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_jdo", 64'(jdo), 64'(dv[0]));
        chk("pp_head", 64'(cmd_data), 64'(dv[1]));
        vs_udr = 1'b0; negs(3);
        cmd_ready = 1'b1; negs(6);
        chk("pp_drain_level", 64'(fifo_level), 64'd0);
        chk("pp_tail_jdo", 64'(jdo), 64'(dv[5]));
        cmd_ready = 1'b0;

        // strobe held across reset release
        sr = dv[2]; vs_udr = 1'b1; reset = 1'b1; negs(2);
        reset = 1'b0; negs(8);
        chk("hold_nopush", 64'(fifo_level), 64'd0);
        vs_udr = 1'b0; negs(3);
        vs_udr = 1'b1; negs(4);
        chk("rise_push", 64'(fifo_level), 64'd1);
        vs_udr = 1'b0; negs(6);
        chk("rise_once", 64'(fifo_level), 64'd1);

        // reset mid-operation with a pop in flight
        do_udr(dv[3]);
        chk("mid_level", 64'(fifo_level), 64'd2);
        cmd_ready = 1'b1; negs(1);
        chk("mid_jdo", 64'(jdo), 64'(dv[2]));
        reset = 1'b1; negs(1); reset = 1'b0;
        chk("mid_valid", 64'(cmd_valid), 64'd0);
        chk("mid_level0", 64'(fifo_level), 64'd0);
        chk("mid_jdo0", 64'(jdo), 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mid_nopulse%0d", i), 64'({take_action, take_no_action}), 64'd0);
            negs(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
